// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared defaults, state type and helpers for the SPI pixel receiver
package spi_rx_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int LINES_DEF      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } rx_state_t;

    // Bit counter must hold the full word count, not just DATA_WIDTH-1.
    function automatic int bit_cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

    localparam int BIT_CNT_W = bit_cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/spi_rx_sync.sv
// rtl/spi_rx_sync.sv - N-bit two-flop synchroniser with a per-bit reset value
//
// Ports:
//   clk_in   - destination clock
//   rst_in   - synchronous active-high reset, loads RESET_VAL into both stages
//   async_in - asynchronous inputs
//   sync_out - inputs after two flop stages
module spi_rx_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/spi_pixel_receiver.sv
// rtl/spi_pixel_receiver.sv - oversampling receiver for the 6-line parallel SPI pixel link
//
// Ports:
//   clk_in          - system clock
//   rst_in          - synchronous active-high reset
//   chip_clk_in     - asynchronous SPI data clock
//   chip_data_in    - asynchronous data, one bit per line
//   chip_sel_in     - asynchronous chip select, active-low
//   pixel_data_out  - reassembled pixel
//   pixel_valid_out - pixel_data_out / hcount_out / vcount_out valid
//   hcount_out      - column of the current pixel
//   vcount_out      - row of the current pixel
//   frame_done_out  - pulse with the last pixel of a frame
//   error_out       - pulse on short packet or overrun
//
// Build option: SPI_RX_ERROR_EN enables error_out; otherwise it stays 0.
module spi_pixel_receiver
    import spi_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int LINES        = LINES_DEF,
    parameter int HRES         = 640,
    parameter int VRES         = 360,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    chip_clk_in,
    input  logic [LINES-1:0]        chip_data_in,
    input  logic                    chip_sel_in,
    output logic [DATA_WIDTH-1:0]   pixel_data_out,
    output logic                    pixel_valid_out,
    output logic [$clog2(HRES)-1:0] hcount_out,
    output logic [$clog2(VRES)-1:0] vcount_out,
    output logic                    frame_done_out,
    output logic                    error_out
);

    localparam int CNT_W = bit_cnt_width(DATA_WIDTH);
    localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int HW    = $clog2(HRES);
    localparam int VW    = $clog2(VRES);
    localparam int IW    = $clog2(IDLE_TIMEOUT + 1);

    logic [LINES+1:0] sync_bus;
    logic             cs_s;
    logic             dclk_s;
    logic [LINES-1:0] data_s;

    // cs idles high, so its stages reset to 1 to avoid a false falling edge.
    spi_rx_sync #(
        .WIDTH     (LINES + 2),
        .RESET_VAL ({1'b1, {(LINES + 1){1'b0}}})
    ) u_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in ({chip_sel_in, chip_clk_in, chip_data_in}),
        .sync_out (sync_bus)
    );

    assign cs_s   = sync_bus[LINES+1];
    assign dclk_s = sync_bus[LINES];
    assign data_s = sync_bus[LINES-1:0];

    rx_state_t             state_q, state_d;
    logic                  dclk_prev_q, dclk_prev_d;
    logic                  cs_prev_q, cs_prev_d;
    logic [DATA_WIDTH-1:0] shift_q [LINES];
    logic [DATA_WIDTH-1:0] shift_d [LINES];
    logic [DATA_WIDTH-1:0] hold_q  [LINES];
    logic [DATA_WIDTH-1:0] hold_d  [LINES];
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      drain_idx_q, drain_idx_d;
    logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [HW-1:0]         hcount_q, hcount_d;
    logic [VW-1:0]         vcount_q, vcount_d;
    logic                  error_q, error_d;

    logic capture;
    logic cs_fall;
    logic cs_rise;
    logic pkt_done;
    logic resync;

    assign capture  = dclk_s & ~dclk_prev_q & ~cs_s;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    // The bit counter runs independently of the FSM so that a packet arriving
    // during DRAIN is still counted and can be recognised as an overrun.
    assign pkt_done = capture && (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
    // Fires on the cycle the idle count reaches the limit, even if cs falls
    // in that same cycle; the FSM still takes the fall.
    assign resync   = (idle_cnt_q == IW'(IDLE_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        bit_cnt_d   = bit_cnt_q;
        drain_idx_d = drain_idx_q;
        idle_cnt_d  = idle_cnt_q;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        error_d     = 1'b0;
        dclk_prev_d = dclk_s;
        cs_prev_d   = cs_s;

        if (capture) begin
            for (int k = 0; k < LINES; k++) begin
                shift_d[k] = {shift_q[k][DATA_WIDTH-2:0], data_s[k]};
            end
        end

        // Saturates at DATA_WIDTH so extra clocks in a packet are ignored.
        if (cs_s) begin
            bit_cnt_d = '0;
        end else if (capture && (bit_cnt_q != CNT_W'(DATA_WIDTH))) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        if (!cs_s) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IW'(IDLE_TIMEOUT)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (pkt_done) begin
                    hold_d      = shift_d;
                    drain_idx_d = IDX_W'(LINES - 1);
                    state_d     = DRAIN;
                end else if (cs_rise) begin
`ifdef SPI_RX_ERROR_EN
                    error_d = (bit_cnt_q != CNT_W'(DATA_WIDTH));
`endif
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // A packet completing here is dropped; the held words stay intact.
`ifdef SPI_RX_ERROR_EN
                error_d = pkt_done;
`endif
                if (drain_idx_q == '0) begin
                    state_d = cs_s ? IDLE : SHIFT;
                end else begin
                    drain_idx_d = drain_idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resync) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (state_q == DRAIN) begin
            if (hcount_q == HW'(HRES - 1)) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VW'(VRES - 1)) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            dclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            for (int k = 0; k < LINES; k++) begin
                shift_q[k] <= '0;
                hold_q[k]  <= '0;
            end
            bit_cnt_q   <= '0;
            drain_idx_q <= '0;
            idle_cnt_q  <= '0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dclk_prev_q <= dclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            bit_cnt_q   <= bit_cnt_d;
            drain_idx_q <= drain_idx_d;
            idle_cnt_q  <= idle_cnt_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            error_q     <= error_d;
        end
    end

    // The counters hold the position of the pixel being emitted this cycle.
    assign pixel_valid_out = (state_q == DRAIN);
    assign pixel_data_out  = pixel_valid_out ? hold_q[drain_idx_q] : '0;
    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign frame_done_out  = pixel_valid_out && (hcount_q == HW'(HRES - 1))
                             && (vcount_q == VW'(VRES - 1));
    assign error_out       = error_q;

endmodule

// File: doc/spi_pixel_receiver.md
# spi_pixel_receiver

Receive end of the 6-line parallel SPI pixel link on the depth-mapping FPGA. Oversamples `chip_clk_in`, `chip_sel_in` and six data lines in the local 100 MHz domain and reassembles one 16-bit pixel per line per packet. Emits the six pixels as a serial stream with 640x360 `hcount`/`vcount`, feeding the stereo/SAD frame store.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per line per packet; also the pixel width.
- `LINES`, 6: parallel data lines, equal to pixels per packet.
- `HRES`, 640: pixels per row.
- `VRES`, 360: rows per frame.
- `IDLE_TIMEOUT`, 100000: consecutive cycles with `chip_sel_in` high that resynchronise the frame counters.

Ports:
- `clk_in`, input, 1: 100 MHz system clock.
- `rst_in`, input, 1: one clock; reset is synchronous and active-high.
- `chip_clk_in`, input, 1: asynchronous SPI data clock, about 16.6 MHz.
- `chip_data_in`, input, LINES: asynchronous data, one bit per line.
- `chip_sel_in`, input, 1: asynchronous chip select, active-low.
- `pixel_data_out`, output, DATA_WIDTH: reassembled pixel.
- `pixel_valid_out`, output, 1: `pixel_data_out`, `hcount_out` and `vcount_out` are valid.
- `hcount_out`, output, $clog2(HRES): column of the current pixel.
- `vcount_out`, output, $clog2(VRES): row of the current pixel.
- `frame_done_out`, output, 1: one-cycle pulse coincident with pixel (HRES-1, VRES-1).
- `error_out`, output, 1: one-cycle pulse on a protocol error.

## Operation
- **Synchronisation:** `chip_clk_in`, `chip_sel_in` and `chip_data_in` each pass through 2 FF stages of equal depth. A rising-edge detector runs on the synced clock.
- **Bit capture:** on a synced `chip_clk_in` rising edge with synced `chip_sel_in` low, shift the synced data MSB-first into `LINES` shift registers. Line k builds word k.
- **State machine:** IDLE, SHIFT, DRAIN.
  - IDLE: falling edge of synced cs → SHIFT, bit counter cleared.
  - SHIFT: on the DATA_WIDTH-th captured bit, latch all words → DRAIN, drain index = LINES-1.
  - SHIFT: cs rises with bit count ≠ DATA_WIDTH → short packet. Discard the words, → IDLE.
  - DRAIN: one word per cycle, order line LINES-1 down to line 0 (oldest pixel first). After line 0 → IDLE, or → SHIFT if cs is already low again.
- **Overrun:** a new packet completes while in DRAIN → drop the new packet and finish the current drain. This cannot happen at the nominal rate (packet ≥ 96 cycles, drain = 6).
- **Counters:**
  - `hcount_out` increments per emitted pixel and wraps HRES-1 → 0.
  - `vcount_out` increments on each hcount wrap and wraps VRES-1 → 0.
  - HRES*VRES must be divisible by LINES (230400/6 = 38400 packets per frame).
- **Idle resync:** a cycle counter counts cycles with synced cs high and saturates at IDLE_TIMEOUT. Reaching IDLE_TIMEOUT zeros `hcount_out`/`vcount_out` and leaves the FSM in IDLE. Any cs low clears the counter.
- **Reset mid-packet:** partial words are discarded, FSM → IDLE, all counters 0.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0.
- Pin-to-capture latency is 3 `clk_in` cycles: 2 sync stages plus the edge detect.
- The first `pixel_valid_out` is asserted the cycle after the 16th bit is captured.
- The six outputs are emitted back-to-back with valid high for 6 consecutive cycles.
- `hcount_out`/`vcount_out` update with each emitted pixel (registered).
- `frame_done_out` and `error_out` are single-cycle pulses.
- Simultaneous reaching of IDLE_TIMEOUT and a cs fall: the cs fall wins, the counters are still zeroed, and the packet is received as pixel (0,0).
- Minimum synced dclk half-period is 2 `clk_in` cycles; faster links are unsupported.

## Configuration
- `SPI_RX_ERROR_EN`:
  - Defined: `error_out` pulses on a short packet or an overrun.
  - Undefined: `error_out` is tied 0. Short packets and overruns are still discarded silently.

## Structure
- Package `spi_rx_pkg`: `DATA_WIDTH`/`LINES` defaults, `rx_state_t` enum (IDLE, SHIFT, DRAIN), bit-counter width constant.
- Sub-module `spi_rx_sync`: parameterised N-bit 2-FF synchroniser. Instantiated once for {cs, clk, data}.

## Test plan
- **Single packet:** lines 5..0 = 0x5555, 0xAAAA, 0x1234, 0xFFFF, 0x0000, 0x8001 at 6-cycle dclk → 0x5555, 0xAAAA, 0x1234, 0xFFFF, 0x0000, 0x8001 on 6 consecutive valid cycles, hcount 0..5, vcount 0.
- **Full frame:** 38400 packets → hcount wraps at 639, vcount reaches 359, `frame_done_out` pulses once on the 230400th pixel, the next pixel is (0,0).
- **Short packet:** cs rises after 9 bits → no `pixel_valid_out`, `error_out` pulses once (macro defined). The following good packet starts at the unchanged hcount.
- **Idle resync:** stop after 100 pixels, hold cs high for 100000 cycles, send a packet → first pixel at hcount 0, vcount 0.
- **Reset mid-packet:** assert `rst_in` after 8 bits, then send a full packet → all outputs 0 during reset, the next packet emitted at (0,0) with correct data.
- **Overrun:** force a packet to complete during DRAIN → the first packet's 6 pixels are intact, the second is dropped, `error_out` pulses once.
